// File: rtl/calc_entry_ctl.sv
// Operand/operator entry sequencer for the BCD keyboard calculator: collects two
// 2-digit BCD operands and an operator, then runs the datapath via start/done.
module calc_entry_ctl #(
  parameter int unsigned CalcTimeout = 255
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       key_valid_i,
  input  logic [8:0] last_change_i,
  input  logic       key_pressed_i,
  input  logic       calc_done_i,
  output logic [3:0] a1_o,
  output logic [3:0] a0_o,
  output logic [3:0] b1_o,
  output logic [3:0] b0_o,
  output logic [1:0] op_o,
  output logic       calc_start_o,
  output logic [1:0] show_stat_o,
  output logic       err_o
);

  localparam int unsigned CntW = $clog2(CalcTimeout);

  typedef enum logic [1:0] {StAEntry, StBEntry, StCalc, StShowF} state_e;

  state_e state_q, state_d;
  logic [3:0] a1_q, a1_d, a0_q, a0_d, b1_q, b1_d, b0_q, b0_d;
  logic [1:0] op_q, op_d;
  logic       cs_q, cs_d, err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic       is_digit, is_op, is_ent, timeout;
  logic [3:0] digit;
  logic [1:0] key_op;

  // Only make events with a recognised code count as keys.
  always_comb begin
    is_digit = 1'b0;
    is_op    = 1'b0;
    is_ent   = 1'b0;
    digit    = 4'd0;
    key_op   = 2'b00;
    if (key_valid_i && key_pressed_i) begin
      case (last_change_i)
        9'h070: begin is_digit = 1'b1; digit = 4'd0; end
        9'h069: begin is_digit = 1'b1; digit = 4'd1; end
        9'h072: begin is_digit = 1'b1; digit = 4'd2; end
        9'h07A: begin is_digit = 1'b1; digit = 4'd3; end
        9'h06B: begin is_digit = 1'b1; digit = 4'd4; end
        9'h073: begin is_digit = 1'b1; digit = 4'd5; end
        9'h074: begin is_digit = 1'b1; digit = 4'd6; end
        9'h06C: begin is_digit = 1'b1; digit = 4'd7; end
        9'h075: begin is_digit = 1'b1; digit = 4'd8; end
        9'h07D: begin is_digit = 1'b1; digit = 4'd9; end
        9'h079: begin is_op = 1'b1; key_op = 2'b01; end
        9'h07B: begin is_op = 1'b1; key_op = 2'b10; end
        9'h07C: begin is_op = 1'b1; key_op = 2'b11; end
        9'h071: is_ent = 1'b1;
        default: ;
      endcase
    end
  end

  // calc_done takes priority over an expiring count.
  assign timeout = (cnt_q == CntW'(CalcTimeout - 1)) && !calc_done_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StAEntry;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAEntry: if (is_op) state_d = StBEntry;
      StBEntry: if (is_ent) state_d = StCalc;
      StCalc:   if (calc_done_i || timeout) state_d = StShowF;
      StShowF: begin
        if (is_digit)    state_d = StAEntry;
        else if (is_op)  state_d = StBEntry;
        else if (is_ent) state_d = StCalc;
      end
      default: state_d = StAEntry;
    endcase
  end

  always_comb begin
    a1_d  = a1_q;
    a0_d  = a0_q;
    b1_d  = b1_q;
    b0_d  = b0_q;
    op_d  = op_q;
    err_d = err_q;
    cs_d  = 1'b0;
    cnt_d = '0;
    unique case (state_q)
      StAEntry: begin
        if (is_digit) begin
          a1_d = a0_q;
          a0_d = digit;
        end else if (is_op) begin
          op_d = key_op;
          b1_d = 4'd0;
          b0_d = 4'd0;
        end
      end
      StBEntry: begin
        if (is_digit) begin
          b1_d = b0_q;
          b0_d = digit;
        end else if (is_op) begin
          op_d = key_op;
        end else if (is_ent) begin
          cs_d  = 1'b1;
          err_d = 1'b0;
        end
      end
      StCalc: begin
        if (calc_done_i) begin
          cnt_d = '0;
        end else if (timeout) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StShowF: begin
        if (is_digit) begin
          a1_d  = 4'd0;
          a0_d  = digit;
          b1_d  = 4'd0;
          b0_d  = 4'd0;
          op_d  = 2'b00;
          err_d = 1'b0;
        end else if (is_op) begin
          op_d  = key_op;
          b1_d  = 4'd0;
          b0_d  = 4'd0;
          err_d = 1'b0;
        end else if (is_ent) begin
          cs_d  = 1'b1;
          err_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a1_q  <= 4'd0;
      a0_q  <= 4'd0;
      b1_q  <= 4'd0;
      b0_q  <= 4'd0;
      op_q  <= 2'b00;
      cs_q  <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      a1_q  <= a1_d;
      a0_q  <= a0_d;
      b1_q  <= b1_d;
      b0_q  <= b0_d;
      op_q  <= op_d;
      cs_q  <= cs_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    unique case (state_q)
      StAEntry: show_stat_o = 2'b00;
      StShowF:  show_stat_o = 2'b10;
      default:  show_stat_o = 2'b01;
    endcase
  end

  assign a1_o         = a1_q;
  assign a0_o         = a0_q;
  assign b1_o         = b1_q;
  assign b0_o         = b0_q;
  assign op_o         = op_q;
  assign calc_start_o = cs_q;
  assign err_o        = err_q;

endmodule

// File: doc/calc_entry_ctl.md
# calc_entry_ctl

Synchronous operand/operator entry sequencer for the keyboard BCD calculator. It consumes decoded PS/2 key events from the keyboard decoder. It accumulates two 2-digit BCD operands and an operator, then starts the shared add/sub/mul datapath with a start/done handshake. It drives the display-select state used by the SSD and VGA paths. It replaces key-edge-clocked capture with a single-clock FSM.

## Interface
- CALC_TIMEOUT, 255: maximum cycles in CALC waiting for calc_done; must be ≥2.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle pulse per decoded key event.
- last_change  in  9  key code for the event, as {extended bit, scan code}.
- key_pressed  in  1  key_down[last_change] for that event: 1 = make, 0 = break.
- calc_done  in  1  datapath result ready; a level or pulse is accepted in CALC.
- a1, a0  out  4 each  operand A tens and ones digits (BCD).
- b1, b0  out  4 each  operand B tens and ones digits (BCD).
- op  out  2  operator: 00 none, 01 add, 10 sub, 11 mul.
- calc_start  out  1  one-cycle start pulse to the datapath.
- show_stat  out  2  display select: 00 show A, 01 show B, 10 show F.
- err  out  1  set when a calculation times out.

## Operation
- Key decode (9-bit codes):
  - Digits: 0=070, 1=069, 2=072, 3=07A, 4=06B, 5=073, 6=074, 7=06C, 8=075, 9=07D.
  - Operators: add=079, sub=07B, mul=07C.
  - Enter: ENT=071.
- A valid event requires key_valid=1 and key_pressed=1. Break events and unlisted codes are ignored in every state.
- Digit shift rule for an operand X: X1 <= X0, X0 <= digit. The old tens digit is discarded.
- States: A_ENTRY, B_ENTRY, CALC, SHOW_F.
- A_ENTRY, show_stat=00:
  - Digit: shift into A.
  - Operator: latch op, clear b1/b0 to 0, go to B_ENTRY.
  - ENT: ignored.
- B_ENTRY, show_stat=01:
  - Digit: shift into B.
  - Operator: replace op; B is unchanged.
  - ENT: assert calc_start, clear err, go to CALC.
- CALC, show_stat=01:
  - All key events are ignored.
  - calc_done=1: go to SHOW_F.
  - Timeout counter reaches CALC_TIMEOUT with no calc_done: set err=1, go to SHOW_F.
  - calc_done wins over timeout on the same cycle.
- SHOW_F, show_stat=10:
  - Digit: clear A, B, op and err, load a0=digit, go to A_ENTRY.
  - Operator: keep A, latch the new op, clear B, clear err, go to B_ENTRY.
  - ENT: recompute with the same operands (calc_start, clear err, go to CALC).
- A, B and op hold stable in CALC and SHOW_F. The datapath reads them combinationally.

## Timing
- Reset (rst=0, asynchronous):
  - State A_ENTRY.
  - a1=a0=b1=b0=0, op=00, calc_start=0, show_stat=00, err=0, timeout counter=0.
- All outputs are registered. An event sampled at edge N is visible after edge N (latency 1 cycle).
- calc_start is high for exactly the first cycle in CALC, never longer. It is never asserted outside an ENT transition.
- Timeout counter:
  - Cleared on CALC entry.
  - Increments on each CALC cycle, starting with the calc_start cycle.
  - Timeout fires on the edge where the count equals CALC_TIMEOUT-1 and calc_done=0.
- calc_done arriving in the calc_start cycle is accepted: SHOW_F on the next edge.
- calc_done outside CALC is ignored.
- Back-to-back key_valid pulses on consecutive cycles are each processed.
- Reset asserted mid-CALC aborts immediately. No calc_start is issued after release until a new ENT.

## Test plan
- Reset, then press 4, 2, add, 1, 7, ENT:
  - a1/a0=4/2; b1/b0=1/7; op=01.
  - calc_start one cycle; show_stat goes 00→01→01→10 after calc_done.
- Press 1, 2, 3 in A_ENTRY -> a1=2, a0=3. Then break events for each -> no change.
- In B_ENTRY press sub then mul -> op=11, b1/b0 unchanged. Press ENT, hold calc_done=0 -> err=1 and show_stat=10 exactly CALC_TIMEOUT cycles after calc_start.
- In SHOW_F:
  - Press 5 -> a1=0, a0=5, b=00, op=00, err=0, show_stat=00.
  - Alternatively press add -> A kept, B=00, op=01, show_stat=01.
- Pulse rst=0 while in CALC -> all outputs return to reset values asynchronously. A later calc_done is ignored.
- In CALC, pulse key_valid with digit 9 and calc_done on the same cycle -> SHOW_F entered, A/B unchanged.
